ofifo_collect: RTL and testbench

- Output-side collector for the chained mac_col array.
- Each mac_col column emits its 32-bit psum on `out` with a one-cycle `fifo_wr` strobe. The columns fire at skewed times because q/inst ripple one column per cycle.
- The block buffers each column in its own FIFO lane and re-aligns the lanes into full rows.
- A row is released to the downstream reader (psum SRAM / SFU) only when every column has contributed its entry.

---
 rtl/ofifo_collect.sv | 59 +++++
 tb/tb_ofifo_collect.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ofifo_collect.sv
// ofifo_collect: per-column psum lanes buffered independently and released as aligned rows
module ofifo_collect #(
  parameter int col     = 8,
  parameter int bw_psum = 32,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*bw_psum-1:0] in,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] dcnt = (aw+1)'(depth);
  logic [col-1:0] nz, fl, drop;
  logic pop;
  assign pop     = rd & o_valid;
  assign o_valid = &nz;
  assign o_full  = |fl;
  assign o_ready = ~o_full;
  genvar j;
  for (j = 0; j < col; j++) begin : g_lane
    logic [bw_psum-1:0] mem [depth];
    logic [bw_psum-1:0] q;
    logic [aw-1:0] wptr, rptr;
    logic [aw:0] cnt;
    logic acc;
    assign nz[j] = cnt != '0;
    assign fl[j] = cnt == dcnt;
    // a pop in the same cycle frees the slot a full lane needs
    assign acc     = wr[j] & (~fl[j] | pop);
    assign drop[j] = wr[j] & fl[j] & ~pop;
    assign out[j*bw_psum +: bw_psum] = q;
    always_ff @(posedge clk)
      if (acc) mem[wptr] <= in[j*bw_psum +: bw_psum];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
        q    <= '0;
      end else begin
        if (acc) wptr <= wptr + 1'b1;
        if (pop) begin
          rptr <= rptr + 1'b1;
          q    <= mem[rptr];
        end
        cnt <= cnt + {{aw{1'b0}}, acc} - {{aw{1'b0}}, pop};
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) o_ovf <= 1'b0;
    else o_ovf <= o_ovf | (|drop);
endmodule

// File: tb/tb_ofifo_collect.sv
// tb_ofifo_collect: directed stimulus with a queue scoreboard checked by an independent pop monitor
module tb_ofifo_collect;
  logic clk = 0, reset = 1, rd = 0;
  logic [7:0] wr = 0;
  logic [255:0] din = 0, out;
  logic o_valid, o_full, o_ready, o_ovf;
  logic [255:0] sb[$];
  int checks = 0, fails = 0;
  bit pend = 0;

  ofifo_collect dut (
    .clk(clk), .reset(reset), .wr(wr), .in(din), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int b);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(b + k);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // out changes one edge after an accepted pop; compare on the following negedge
  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pop got=%h exp=none", out);
      end else chk("pop_row", out, sb.pop_front());
    end
    pend = rd & o_valid & ~reset;
  end

  initial begin
    #2;
    chk("rst_out", out, 0);
    chk("rst_valid", 256'(o_valid), 0);
    chk("rst_full", 256'(o_full), 0);
    chk("rst_ready", 256'(o_ready), 1);
    chk("rst_ovf", 256'(o_ovf), 0);
    tick; tick;
    reset = 0;
    tick;
    // 1: staggered lane writes, rd held high
    for (int j = 0; j < 8; j++) begin
      chk("t1_valid_low", 256'(o_valid), 0);
      wr = 8'(1 << j);
      din = mk(100);
      rd = 1;
      if (j == 7) sb.push_back(mk(100));
      tick;
    end
    wr = 0;
    chk("t1_valid_high", 256'(o_valid), 1);
    tick;
    rd = 0;
    chk("t1_valid_drop", 256'(o_valid), 0);
    tick;
    // 2/3: fill all lanes, then simultaneous write+pop on a full array
    for (int r = 0; r < 16; r++) begin
      wr = 8'hff;
      din = mk(r * 8);
      tick;
    end
    wr = 0;
    chk("t2_full", 256'(o_full), 1);
    chk("t2_ready", 256'(o_ready), 0);
    wr = 8'hff;
    din = mk(128);
    rd = 1;
    sb.push_back(mk(0));
    tick;
    wr = 0;
    rd = 0;
    chk("t3_full", 256'(o_full), 1);
    chk("t3_ovf", 256'(o_ovf), 0);
    wr = 8'h08;
    din = 0;
    din[3*32 +: 32] = 32'd999;
    tick;
    wr = 0;
    chk("t2_ovf", 256'(o_ovf), 1);
    chk("t2_full_kept", 256'(o_full), 1);
    tick;
    chk("t3_row0", out, mk(0));
    for (int r = 1; r <= 16; r++) sb.push_back(mk(r * 8));
    rd = 1;
    for (int r = 0; r < 16; r++) tick;
    rd = 0;
    chk("t2_drained", 256'(o_valid), 0);
    chk("t2_not_full", 256'(o_full), 0);
    tick;
    chk("t2_last_row", out, mk(128));
    // 4: refused pop while lane 5 is empty
    wr = 8'hdf;
    din = mk(200);
    tick;
    wr = 0;
    rd = 1;
    tick;
    rd = 0;
    chk("t4_valid", 256'(o_valid), 0);
    tick;
    chk("t4_out_hold", out, mk(128));
    wr = 8'h20;
    tick;
    wr = 0;
    chk("t4_valid_now", 256'(o_valid), 1);
    sb.push_back(mk(200));
    rd = 1;
    tick;
    rd = 0;
    chk("t4_single_entry", 256'(o_valid), 0);
    tick;
    // 5: streaming across pointer wrap
    for (int i = 0; i < 40; i++) sb.push_back(mk(1000 + i * 8));
    for (int i = 0; i < 40; i++) begin
      wr = 8'hff;
      din = mk(1000 + i * 8);
      rd = 1;
      tick;
    end
    wr = 0;
    tick;
    rd = 0;
    tick;
    chk("t5_drained", 256'(sb.size()), 0);
    chk("t5_empty", 256'(o_valid), 0);
    // 6: async reset with rows buffered
    for (int r = 0; r < 5; r++) begin
      wr = 8'hff;
      din = mk(3000 + r * 8);
      tick;
    end
    wr = 0;
    chk("t6_pre_valid", 256'(o_valid), 1);
    #2 reset = 1;
    #1;
    chk("t6_out", out, 0);
    chk("t6_valid", 256'(o_valid), 0);
    chk("t6_ovf", 256'(o_ovf), 0);
    chk("t6_ready", 256'(o_ready), 1);
    #3 reset = 0;
    tick;
    wr = 8'hff;
    din = mk(4000);
    tick;
    wr = 0;
    sb.push_back(mk(4000));
    rd = 1;
    tick;
    rd = 0;
    tick;
    tick;
    chk("end_sb_empty", 256'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
